// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the sync_fifo codebase slice.
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Pointer carries one extra wrap bit above the RAM address.
  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with a resettable
// output register (the array contents are never cleared).
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with fill count, almost flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH          = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   fill_count
);

  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Handshake: wr_en/rd_en are single-cycle requests. A request is accepted at
  // the rising edge only if full (write) / empty (read), derived from registered
  // state, is low; a rejected request is dropped and raises a one-cycle
  // overflow/underflow pulse after that edge.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;
  logic                ram_rd;

  assign wr_acc = wr_en && !full;

`ifdef SYNC_FIFO_FWFT_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));

  // The RAM read register doubles as the output stage; out_valid marks it live.
  logic out_valid;
  logic ram_empty;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign empty     = !out_valid;
  assign full      = (fill_count == DEPTH_CNT);
  assign rd_acc    = rd_en && out_valid;
  assign ram_rd    = !ram_empty && (!out_valid || rd_acc);

  always_ff @(posedge clk) begin
    if (reset) out_valid <= 1'b0;
    else if (ram_rd) out_valid <= 1'b1;
    else if (rd_acc) out_valid <= 1'b0;
  end
`else
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign rd_acc = rd_en && !empty;
  assign ram_rd = rd_acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_rd) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      case ({wr_acc, rd_acc})
        2'b10:   fill_count <= fill_count + PTR_ONE;
        2'b01:   fill_count <= fill_count - PTR_ONE;
        default: fill_count <= fill_count;
      endcase
    end
  end

  assign almost_full  = (fill_count >= AF_LVL);
  assign almost_empty = (fill_count <= AE_LVL);

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=4) with an
// expected-data queue; the FWFT scenario is selected by SYNC_FIFO_FWFT_EN.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = fifo_depth(FIFO_ADDR_WIDTH);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       full, almost_full, overflow, empty, almost_empty, underflow;
  logic [7:0] data_out;
  logic [4:0] fill_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_pop;
  logic [7:0] m_data;
  ptr_t       m_count;
  logic       m_ovf, m_udf, popped;

  sync_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .data_out     (data_out),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow),
    .fill_count   (fill_count)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_count = '0; m_data = '0; m_ovf = 1'b0; m_udf = 1'b0; popped = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset.empty got %0b exp 1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset.almost_empty got %0b exp 1", almost_empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset.full got %0b exp 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset.almost_full got %0b exp 0", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset.overflow got %0b exp 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset.underflow got %0b exp 0", underflow); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset.data_out got %0h exp 0", data_out); end
    checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL reset.fill_count got %0d exp 0", fill_count); end
  endtask

`ifdef SYNC_FIFO_FWFT_EN

  task automatic test_fwft();
    wr_en = 1'b1; data_in = 8'h3C; exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwft.prefetch_empty got %0b exp 1", empty); end
    @(posedge clk); #1;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fwft.shown_empty got %0b exp 0", empty); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL fwft.shown_data got %0h exp 3c", data_out); end
    checks++; if (fill_count !== 5'd1) begin errors++; $display("FAIL fwft.fill1 got %0d exp 1", fill_count); end
    for (int i = 1; i < 4; i++) begin
      wr_en = 1'b1; data_in = 8'h3C + 8'(i); exp_q.push_back(data_in);
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    checks++; if (fill_count !== 5'd4) begin errors++; $display("FAIL fwft.fill4 got %0d exp 4", fill_count); end
    for (int i = 0; i < 4; i++) begin
      exp_pop = exp_q.pop_front();
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fwft.stream_empty[%0d] got %0b exp 0", i, empty); end
      checks++; if (data_out !== exp_pop) begin errors++; $display("FAIL fwft.stream_data[%0d] got %0h exp %0h", i, data_out, exp_pop); end
      rd_en = 1'b1;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwft.drained_empty got %0b exp 1", empty); end
    checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL fwft.drained_fill got %0d exp 0", fill_count); end
  endtask

`else

  // One clock of stimulus; updates the reference model for the edge just taken.
  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    logic wa, ra;
    wa = w && (m_count != 5'(DEPTH));
    ra = r && (m_count != 5'd0);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    if (ra) begin exp_pop = exp_q.pop_front(); m_data = exp_pop; end
    if (wa) exp_q.push_back(d);
    m_count = m_count + 5'(wa) - 5'(ra);
    m_ovf = w && !wa;
    m_udf = r && !ra;
    popped = ra;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      checks++; if (fill_count !== m_count) begin errors++; $display("FAIL fill.count got %0d exp %0d", fill_count, m_count); end
      checks++; if (full !== (m_count == 5'd16)) begin errors++; $display("FAIL fill.full got %0b at count %0d", full, m_count); end
      checks++; if (almost_full !== (m_count >= 5'd14)) begin errors++; $display("FAIL fill.almost_full got %0b at count %0d", almost_full, m_count); end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== 8'(i)) begin errors++; $display("FAIL drain.data got %0h exp %0h", data_out, 8'(i)); end
      checks++; if (empty !== (m_count == 5'd0)) begin errors++; $display("FAIL drain.empty got %0b at count %0d", empty, m_count); end
      checks++; if (almost_empty !== (m_count <= 5'd2)) begin errors++; $display("FAIL drain.almost_empty got %0b at count %0d", almost_empty, m_count); end
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'hEE, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf.pulse got %0b exp 1", overflow); end
    checks++; if (fill_count !== 5'd16) begin errors++; $display("FAIL ovf.fill got %0d exp 16", fill_count); end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf.one_cycle got %0b exp 0", overflow); end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL ovf.next_read got %0h exp 0", data_out); end
    for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf.pulse got %0b exp 1", underflow); end
    checks++; if (data_out !== m_data) begin errors++; $display("FAIL udf.data_held got %0h exp %0h", data_out, m_data); end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf.one_cycle got %0b exp 0", underflow); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      checks++; if (data_out !== exp_pop) begin errors++; $display("FAIL wrap.data[%0d] got %0h exp %0h", i, data_out, exp_pop); end
      checks++; if (fill_count !== 5'd5) begin errors++; $display("FAIL wrap.fill[%0d] got %0d exp 5", i, fill_count); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== exp_pop) begin errors++; $display("FAIL wrap.drain[%0d] got %0h exp %0h", i, data_out, exp_pop); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b1, 8'h77, 1'b1);
    checks++; if (data_out !== exp_pop) begin errors++; $display("FAIL simul_full.data got %0h exp %0h", data_out, exp_pop); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_full.overflow got %0b exp 1", overflow); end
    checks++; if (fill_count !== 5'd15) begin errors++; $display("FAIL simul_full.fill got %0d exp 15", fill_count); end
    for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h99, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simul_empty.underflow got %0b exp 1", underflow); end
    checks++; if (fill_count !== 5'd1) begin errors++; $display("FAIL simul_empty.fill got %0d exp 1", fill_count); end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h99) begin errors++; $display("FAIL simul_empty.data got %0h exp 99", data_out); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (fill_count !== 5'd9) begin errors++; $display("FAIL rmid.pre_fill got %0d exp 9", fill_count); end
    reset_dut();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid.empty got %0b exp 1", empty); end
    checks++; if (fill_count !== 5'd0) begin errors++; $display("FAIL rmid.fill got %0d exp 0", fill_count); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rmid.data got %0h exp 0", data_out); end
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL rmid.after got %0h exp a5", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid.after_empty got %0b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    int wp;
    for (int i = 0; i < 300; i++) begin
      wp = (i < 100) ? 80 : ((i < 200) ? 20 : 50);
      drive(($urandom_range(0, 99) < wp), 8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 50));
      if (popped) begin
        checks++; if (data_out !== exp_pop) begin errors++; $display("FAIL b2b.data[%0d] got %0h exp %0h", i, data_out, exp_pop); end
      end
      checks++; if (fill_count !== m_count) begin errors++; $display("FAIL b2b.fill[%0d] got %0d exp %0d", i, fill_count, m_count); end
      checks++; if (full !== (m_count == 5'd16)) begin errors++; $display("FAIL b2b.full[%0d] got %0b exp %0b", i, full, (m_count == 5'd16)); end
      checks++; if (almost_full !== (m_count >= 5'd14)) begin errors++; $display("FAIL b2b.almost_full[%0d] got %0b", i, almost_full); end
      checks++; if (empty !== (m_count == 5'd0)) begin errors++; $display("FAIL b2b.empty[%0d] got %0b exp %0b", i, empty, (m_count == 5'd0)); end
      checks++; if (almost_empty !== (m_count <= 5'd2)) begin errors++; $display("FAIL b2b.almost_empty[%0d] got %0b", i, almost_empty); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL b2b.overflow[%0d] got %0b exp %0b", i, overflow, m_ovf); end
      checks++; if (underflow !== m_udf) begin errors++; $display("FAIL b2b.underflow[%0d] got %0b exp %0b", i, underflow, m_udf); end
    end
  endtask

`endif

  initial begin
    test_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`else
    test_fill_drain();
    test_overflow_underflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
